// File: rtl/crypto_buf_agent.sv
// rtl/crypto_buf_agent.sv - host/crypto ping-pong buffer agent with protocol error tracking
// Optional CRYPTO_BUF_AGENT_ERRCNT_EN adds a saturating 16-bit ErrCnt output.
module crypto_buf_agent #(
  parameter int AW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          HostWrEn,
  input  logic [AW-1:0] HostWrAddr,
  input  logic [127:0]  HostWrData,
  input  logic          HostIbPost,
  input  logic          HostRdEn,
  input  logic [AW-1:0] HostRdAddr,
  output logic [127:0]  HostRdData,
  output logic          HostObReady,
  input  logic          HostObDone,
  input  logic          RdEn,
  input  logic [31:0]   RdAddr,
  output logic [127:0]  RdData,
  input  logic          WrEn,
  input  logic [31:0]   WrAddr,
  input  logic [127:0]  WrData,
  output logic          IbPCIeValid,
  input  logic          IbIPSECValid,
  output logic          ObPCIeValid,
  input  logic          ObIPSECValid,
  output logic          ErrFlag,
  input  logic          ErrClr
`ifdef CRYPTO_BUF_AGENT_ERRCNT_EN
  ,
  output logic [15:0]   ErrCnt
`endif
);

  localparam int DEPTH = 2 ** AW;

  typedef enum logic {IB_FILL, IB_POST} ib_state_t;
  typedef enum logic {OB_FREE, OB_FULL} ob_state_t;

  ib_state_t ib_state;
  ob_state_t ob_state;

  logic [127:0] ib_mem [DEPTH];
  logic [127:0] ob_mem [DEPTH];

  logic rd_in_range, wr_in_range;
  logic host_wr_ok, host_rd_ok, crypto_rd_ok, crypto_wr_ok;
  logic err_evt;

  assign rd_in_range  = (RdAddr[31:AW] == '0);
  assign wr_in_range  = (WrAddr[31:AW] == '0);
  assign host_wr_ok   = HostWrEn && (ib_state == IB_FILL);
  assign crypto_rd_ok = RdEn && (ib_state == IB_POST) && rd_in_range;
  assign crypto_wr_ok = WrEn && (ob_state == OB_FREE) && wr_in_range;
  assign host_rd_ok   = HostRdEn && (ob_state == OB_FULL);

  assign err_evt = (HostWrEn && !host_wr_ok) || (RdEn && !crypto_rd_ok) ||
                   (WrEn && !crypto_wr_ok) || (HostRdEn && !host_rd_ok) ||
                   (HostIbPost && ib_state == IB_POST) ||
                   (IbIPSECValid && ib_state == IB_FILL) ||
                   (ObIPSECValid && ob_state == OB_FULL) ||
                   (HostObDone && ob_state == OB_FREE);

  // Buffer storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (host_wr_ok)   ib_mem[HostWrAddr] <= HostWrData;
    if (crypto_wr_ok) ob_mem[WrAddr[AW-1:0]] <= WrData;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      RdData     <= '0;
      HostRdData <= '0;
    end else begin
      if (RdEn)     RdData     <= crypto_rd_ok ? ib_mem[RdAddr[AW-1:0]] : '0;
      if (HostRdEn) HostRdData <= host_rd_ok ? ob_mem[HostRdAddr] : '0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ib_state    <= IB_FILL;
      IbPCIeValid <= 1'b0;
    end else begin
      case (ib_state)
        IB_FILL: if (HostIbPost) begin
          ib_state    <= IB_POST;
          IbPCIeValid <= 1'b1;
        end
        IB_POST: if (IbIPSECValid) begin
          ib_state    <= IB_FILL;
          IbPCIeValid <= 1'b0;
        end
        default: begin
          ib_state    <= IB_FILL;
          IbPCIeValid <= 1'b0;
        end
      endcase
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      ob_state    <= OB_FREE;
      ObPCIeValid <= 1'b1;
      HostObReady <= 1'b0;
    end else begin
      case (ob_state)
        OB_FREE: if (ObIPSECValid) begin
          ob_state    <= OB_FULL;
          ObPCIeValid <= 1'b0;
          HostObReady <= 1'b1;
        end
        OB_FULL: if (HostObDone) begin
          ob_state    <= OB_FREE;
          ObPCIeValid <= 1'b1;
          HostObReady <= 1'b0;
        end
        default: begin
          ob_state    <= OB_FREE;
          ObPCIeValid <= 1'b1;
          HostObReady <= 1'b0;
        end
      endcase
    end
  end

  // A new error wins over a same-cycle clear so no event is ever lost.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)       ErrFlag <= 1'b0;
    else if (err_evt) ErrFlag <= 1'b1;
    else if (ErrClr)  ErrFlag <= 1'b0;
  end

`ifdef CRYPTO_BUF_AGENT_ERRCNT_EN
  logic [15:0] err_cnt;
  assign ErrCnt = err_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)
      err_cnt <= '0;
    else if (ErrClr)
      err_cnt <= err_evt ? 16'd1 : 16'd0;
    else if (err_evt && err_cnt != 16'hFFFF)
      err_cnt <= err_cnt + 16'd1;
  end
`endif

endmodule

// File: tb/tb_crypto_buf_agent.sv
// tb/tb_crypto_buf_agent.sv - directed scoreboard bench for crypto_buf_agent
// Covers the CRYPTO_BUF_AGENT_ERRCNT_EN counter when that macro is defined.
module tb_crypto_buf_agent;

  localparam int AW = 8;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          HostWrEn;
  logic [AW-1:0] HostWrAddr;
  logic [127:0]  HostWrData;
  logic          HostIbPost;
  logic          HostRdEn;
  logic [AW-1:0] HostRdAddr;
  logic [127:0]  HostRdData;
  logic          HostObReady;
  logic          HostObDone;
  logic          RdEn;
  logic [31:0]   RdAddr;
  logic [127:0]  RdData;
  logic          WrEn;
  logic [31:0]   WrAddr;
  logic [127:0]  WrData;
  logic          IbPCIeValid;
  logic          IbIPSECValid;
  logic          ObPCIeValid;
  logic          ObIPSECValid;
  logic          ErrFlag;
  logic          ErrClr;
`ifdef CRYPTO_BUF_AGENT_ERRCNT_EN
  logic [15:0]   ErrCnt;
`endif

  int n_tests = 0;
  int n_fail  = 0;

  logic [127:0] exp_q[$];
  string        tag_q[$];

  always #5 clk = ~clk;

  crypto_buf_agent #(.AW(AW)) dut (
    .clk(clk), .rst_n(rst_n),
    .HostWrEn(HostWrEn), .HostWrAddr(HostWrAddr), .HostWrData(HostWrData),
    .HostIbPost(HostIbPost),
    .HostRdEn(HostRdEn), .HostRdAddr(HostRdAddr), .HostRdData(HostRdData),
    .HostObReady(HostObReady), .HostObDone(HostObDone),
    .RdEn(RdEn), .RdAddr(RdAddr), .RdData(RdData),
    .WrEn(WrEn), .WrAddr(WrAddr), .WrData(WrData),
    .IbPCIeValid(IbPCIeValid), .IbIPSECValid(IbIPSECValid),
    .ObPCIeValid(ObPCIeValid), .ObIPSECValid(ObIPSECValid),
    .ErrFlag(ErrFlag), .ErrClr(ErrClr)
`ifdef CRYPTO_BUF_AGENT_ERRCNT_EN
    , .ErrCnt(ErrCnt)
`endif
  );

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the edge; single-cycle controls then drop.
  task automatic tick;
    @(posedge clk);
    #1;
    HostWrEn = 0; HostIbPost = 0; HostRdEn = 0; HostObDone = 0;
    RdEn = 0; WrEn = 0; IbIPSECValid = 0; ObIPSECValid = 0; ErrClr = 0;
  endtask

  task automatic host_wr(input logic [AW-1:0] a, input logic [127:0] d, input logic post);
    HostWrEn = 1; HostWrAddr = a; HostWrData = d; HostIbPost = post;
    tick();
  endtask

  task automatic crypto_wr(input logic [31:0] a, input logic [127:0] d, input logic fin);
    WrEn = 1; WrAddr = a; WrData = d; ObIPSECValid = fin;
    tick();
  endtask

  task automatic crypto_rd(input logic [31:0] a, input logic [127:0] e, input string tag);
    RdEn = 1; RdAddr = a;
    exp_q.push_back(e); tag_q.push_back(tag);
    tick();
    chk(tag_q.pop_front(), RdData, exp_q.pop_front());
  endtask

  task automatic host_rd(input logic [AW-1:0] a, input logic [127:0] e, input string tag);
    HostRdEn = 1; HostRdAddr = a;
    exp_q.push_back(e); tag_q.push_back(tag);
    tick();
    chk(tag_q.pop_front(), HostRdData, exp_q.pop_front());
  endtask

  task automatic clear_err;
    ErrClr = 1;
    tick();
    chk("err_cleared", {127'b0, ErrFlag}, 128'd0);
  endtask

  initial begin
    rst_n = 0;
    HostWrEn = 0; HostWrAddr = '0; HostWrData = '0; HostIbPost = 0;
    HostRdEn = 0; HostRdAddr = '0; HostObDone = 0;
    RdEn = 0; RdAddr = '0; WrEn = 0; WrAddr = '0; WrData = '0;
    IbIPSECValid = 0; ObIPSECValid = 0; ErrClr = 0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_ib_valid", {127'b0, IbPCIeValid}, 128'd0);
    chk("rst_ob_valid", {127'b0, ObPCIeValid}, 128'd1);
    chk("rst_ob_ready", {127'b0, HostObReady}, 128'd0);
    chk("rst_rddata", RdData, 128'd0);
    chk("rst_hostrddata", HostRdData, 128'd0);
    chk("rst_errflag", {127'b0, ErrFlag}, 128'd0);
    rst_n = 1;
    tick();

    // Inbound load; last word written in the same cycle as the post.
    for (int i = 0; i < 3; i++) host_wr(AW'(i), 128'(i + 1), 1'b0);
    host_wr(AW'(3), 128'h4, 1'b1);
    chk("ib_posted", {127'b0, IbPCIeValid}, 128'd1);
    chk("no_err_load", {127'b0, ErrFlag}, 128'd0);
    crypto_rd(32'd2, 128'h3, "rd_word2");
    crypto_rd(32'd3, 128'h4, "rd_word3_post_same_cycle");

    host_wr(AW'(0), 128'hFF, 1'b0);
    chk("err_host_wr_in_post", {127'b0, ErrFlag}, 128'd1);
    clear_err();
    crypto_rd(32'd0, 128'h1, "refused_wr_unchanged");

    crypto_rd(32'h100, 128'h0, "rd_out_of_range");
    chk("err_oor_rd", {127'b0, ErrFlag}, 128'd1);
    clear_err();
    crypto_rd(32'd1, 128'h2, "rd_word1");
    tick();
    chk("rddata_hold", RdData, 128'h2);

    IbIPSECValid = 1;
    tick();
    chk("ib_released", {127'b0, IbPCIeValid}, 128'd0);
    host_wr(AW'(0), 128'hAA, 1'b0);
    chk("no_err_wr_after_release", {127'b0, ErrFlag}, 128'd0);
    crypto_rd(32'd0, 128'h0, "rd_in_fill_refused");
    chk("err_rd_in_fill", {127'b0, ErrFlag}, 128'd1);
    ErrClr = 1;
    tick();
    chk("clr_alone", {127'b0, ErrFlag}, 128'd0);
    IbIPSECValid = 1; ErrClr = 1;
    tick();
    chk("evt_beats_clr", {127'b0, ErrFlag}, 128'd1);
    chk("ib_state_kept", {127'b0, IbPCIeValid}, 128'd0);
    clear_err();
    HostIbPost = 1;
    tick();
    crypto_rd(32'd0, 128'hAA, "rd_new_word0");
    IbIPSECValid = 1;
    tick();

    // Outbound path.
    host_rd(AW'(0), 128'h0, "hostrd_in_free_refused");
    chk("err_hostrd_free", {127'b0, ErrFlag}, 128'd1);
    clear_err();
    crypto_wr(32'd5, 128'hBEEF, 1'b1);
    chk("ob_full_pcie", {127'b0, ObPCIeValid}, 128'd0);
    chk("ob_full_ready", {127'b0, HostObReady}, 128'd1);
    chk("no_err_ob_fill", {127'b0, ErrFlag}, 128'd0);
    host_rd(AW'(5), 128'hBEEF, "hostrd_word5");
    crypto_wr(32'd5, 128'h55, 1'b0);
    chk("err_wr_in_full", {127'b0, ErrFlag}, 128'd1);
    host_rd(AW'(5), 128'hBEEF, "refused_crypto_wr");
    clear_err();
    HostObDone = 1;
    tick();
    chk("ob_freed_pcie", {127'b0, ObPCIeValid}, 128'd1);
    chk("ob_freed_ready", {127'b0, HostObReady}, 128'd0);
    HostObDone = 1;
    tick();
    chk("err_done_in_free", {127'b0, ErrFlag}, 128'd1);
    clear_err();
    crypto_wr(32'h105, 128'h1234, 1'b0);
    chk("err_oor_wr", {127'b0, ErrFlag}, 128'd1);
    clear_err();
    ObIPSECValid = 1;
    tick();
    host_rd(AW'(5), 128'hBEEF, "oor_wr_unchanged");
    tick();
    chk("hostrddata_hold", HostRdData, 128'hBEEF);

    // Both paths in the same cycle.
    HostIbPost = 1; HostObDone = 1;
    tick();
    chk("dual_ib", {127'b0, IbPCIeValid}, 128'd1);
    chk("dual_ob_pcie", {127'b0, ObPCIeValid}, 128'd1);
    chk("dual_ob_ready", {127'b0, HostObReady}, 128'd0);
    chk("dual_no_err", {127'b0, ErrFlag}, 128'd0);
    ObIPSECValid = 1;
    tick();

    // Reset mid-handshake must take effect without a clock edge.
    rst_n = 0;
    #2;
    chk("async_ib_valid", {127'b0, IbPCIeValid}, 128'd0);
    chk("async_ob_valid", {127'b0, ObPCIeValid}, 128'd1);
    chk("async_ob_ready", {127'b0, HostObReady}, 128'd0);
    tick();
    rst_n = 1;
    tick();

`ifdef CRYPTO_BUF_AGENT_ERRCNT_EN
    chk("cnt_reset", {112'b0, ErrCnt}, 128'd0);
    HostIbPost = 1;
    tick();
    for (int i = 0; i < 3; i++) begin
      HostIbPost = 1;
      tick();
    end
    chk("cnt_three", {112'b0, ErrCnt}, 128'd3);
    force dut.err_cnt = 16'hFFFF;
    #1;
    release dut.err_cnt;
    HostIbPost = 1;
    tick();
    chk("cnt_saturate", {112'b0, ErrCnt}, 128'hFFFF);
    ErrClr = 1;
    tick();
    chk("cnt_clear", {112'b0, ErrCnt}, 128'd0);
`endif

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
